cache_miss_ctrl: RTL and testbench

Parametrised miss handler shared by the instruction and data caches. It arbitrates I- and D-cache misses onto one word-wide memory port, writes back a dirty D-cache victim line, then fills the missing line one word at a time. It drives the cache-array write strobes and signals completion to each requester. It sits between the two cache arrays and the memory model, and replaces the fixed five-cycle counter scheme with handshaked, multi-word line transfers.

---
 rtl/cache_miss_ctrl_if.sv | 40 ++++
 rtl/cache_miss_ctrl.sv | 154 +++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_ctrl_if.sv
// Bundle of the cache-side and memory-side signals of the shared miss handler.
// master = the controller, slave = the caches and the memory model.
interface cache_miss_ctrl_if #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned WORDS_PER_LINE = 4
);
    localparam int unsigned OFS_W = $clog2(WORDS_PER_LINE);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_victim_dirty;
    logic [ADDR_W-1:0] d_victim_addr;
    logic              mem_rdy;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              wb_rd;
    logic              fill_we;
    logic              fill_sel;
    logic [OFS_W-1:0]  word_idx;
    logic              i_done;
    logic              d_done;
    logic              busy;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_victim_dirty, d_victim_addr, mem_rdy,
        output mem_re, mem_we, mem_addr, wb_rd, fill_we,
        output fill_sel, word_idx, i_done, d_done, busy
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_victim_dirty, d_victim_addr, mem_rdy,
        input  mem_re, mem_we, mem_addr, wb_rd, fill_we,
        input  fill_sel, word_idx, i_done, d_done, busy
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Shared I/D miss handler: arbitrates misses, writes back a dirty D victim line, fills the line.
// Define CACHE_MISS_CTRL_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module cache_miss_ctrl #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input logic               clk,
    input logic               rst,
    cache_miss_ctrl_if.master bus
);
    localparam int unsigned       OFS_W     = $clog2(WORDS_PER_LINE);
    localparam logic [OFS_W-1:0]  LAST_WORD = OFS_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [OFS_W-1:0]  cnt_q, cnt_n;
    logic              ptr_d_q, ptr_d_n;
    logic              sel_q, sel_n;
    logic              dirty_q, dirty_n;
    logic [ADDR_W-1:0] miss_base_q, miss_base_n;
    logic [ADDR_W-1:0] vict_base_q, vict_base_n;
    logic              grant_d;

    logic              mem_re_q, mem_re_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [OFS_W-1:0]  word_idx_q, word_idx_n;
    logic              i_done_q, i_done_n;
    logic              d_done_q, d_done_n;
    logic              busy_q, busy_n;

    // Winner when sampled in IDLE: 1 = D, 0 = I
    always_comb begin
`ifdef CACHE_MISS_CTRL_RR_EN
        grant_d = (bus.i_miss && bus.d_miss) ? ptr_d_q : bus.d_miss;
`else
        grant_d = bus.d_miss;
`endif
    end

    // Next state, transaction context and next registered outputs
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        ptr_d_n     = ptr_d_q;
        sel_n       = sel_q;
        dirty_n     = dirty_q;
        miss_base_n = miss_base_q;
        vict_base_n = vict_base_q;

        case (state_q)
            IDLE: begin
                if (bus.i_miss || bus.d_miss) begin
                    sel_n       = grant_d;
                    miss_base_n = (grant_d ? bus.d_miss_addr : bus.i_miss_addr) & BASE_MASK;
                    vict_base_n = bus.d_victim_addr & BASE_MASK;
                    dirty_n     = bus.d_victim_dirty;
                    cnt_n       = '0;
`ifdef CACHE_MISS_CTRL_RR_EN
                    ptr_d_n     = ~grant_d;
`endif
                    state_n     = (grant_d && bus.d_victim_dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (bus.mem_rdy) begin
                    cnt_n = cnt_q + OFS_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_n = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.mem_rdy) begin
                    cnt_n = cnt_q + OFS_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        mem_re_n   = (state_n == FILL);
        mem_we_n   = (state_n == WRITEBACK);
        i_done_n   = (state_n == DONE) && !sel_n;
        d_done_n   = (state_n == DONE) && sel_n;
        busy_n     = (state_n != IDLE);
        mem_addr_n = ((state_n == WRITEBACK) ? vict_base_n : miss_base_n) | ADDR_W'(cnt_n);
        word_idx_n = word_idx_q;
        if (state_n == WRITEBACK || state_n == FILL) begin
            word_idx_n = cnt_n;
        end
    end

    // State, context and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_d_q     <= 1'b1;
            sel_q       <= 1'b0;
            dirty_q     <= 1'b0;
            miss_base_q <= '0;
            vict_base_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            word_idx_q  <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            ptr_d_q     <= ptr_d_n;
            sel_q       <= sel_n;
            dirty_q     <= dirty_n;
            miss_base_q <= miss_base_n;
            vict_base_q <= vict_base_n;
            mem_re_q    <= mem_re_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            word_idx_q  <= word_idx_n;
            i_done_q    <= i_done_n;
            d_done_q    <= d_done_n;
            busy_q      <= busy_n;
        end
    end

    // fill_we must follow mem_rdy within the same cycle, so it is the one combinational output
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.wb_rd    = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.fill_we  = mem_re_q & bus.mem_rdy;
    assign bus.fill_sel = sel_q;
    assign bus.word_idx = word_idx_q;
    assign bus.i_done   = i_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed scenarios plus random traffic against a transfer-queue model.
module tb_cache_miss_ctrl;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned WPL     = 4;
    localparam int unsigned OFS_W   = $clog2(WPL);
    localparam int unsigned ADDR_W2 = 12;
    localparam int unsigned WPL2    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_miss_ctrl_if #(.ADDR_W(ADDR_W),  .WORDS_PER_LINE(WPL))  bus  ();
    cache_miss_ctrl_if #(.ADDR_W(ADDR_W2), .WORDS_PER_LINE(WPL2)) bus2 ();

    cache_miss_ctrl #(.ADDR_W(ADDR_W),  .WORDS_PER_LINE(WPL))  dut  (.clk(clk), .rst(rst), .bus(bus));
    cache_miss_ctrl #(.ADDR_W(ADDR_W2), .WORDS_PER_LINE(WPL2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // One expected memory-word transfer, or the closing done pulse
    typedef struct {
        logic              done;
        logic              wr;
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [OFS_W-1:0]  idx;
    } item_t;

    item_t            q[$];
    logic             m_sel;
    logic [OFS_W-1:0] m_idx;
`ifdef CACHE_MISS_CTRL_RR_EN
    logic             m_ptr_d;
`endif
    logic drop_i = 1'b0, drop_d = 1'b0, just_i = 1'b0, just_d = 1'b0;
    logic obs_i_done, obs_d_done;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sel = 1'b0;
        m_idx = '0;
`ifdef CACHE_MISS_CTRL_RR_EN
        m_ptr_d = 1'b1;
`endif
    endtask

    // Compare this cycle's outputs with the head of the expected transfer queue
    task automatic check_outputs();
        item_t      h;
        logic [6:0] o;
        o = {bus.mem_re, bus.mem_we, bus.wb_rd, bus.fill_we, bus.i_done, bus.d_done, bus.busy};
        obs_i_done = bus.i_done;
        obs_d_done = bus.d_done;
        if (q.size() == 0) begin
            chk("idle_ctrl", 32'(o), 32'd0);
            chk("idle_fill_sel", 32'(bus.fill_sel), 32'(m_sel));
            chk("idle_word_idx", 32'(bus.word_idx), 32'(m_idx));
        end else begin
            h = q[0];
            if (h.done) begin
                chk("done_ctrl", 32'(o), 32'({4'b0000, !h.sel, h.sel, 1'b1}));
                chk("done_fill_sel", 32'(bus.fill_sel), 32'(h.sel));
            end else begin
                chk("xfer_ctrl", 32'(o),
                    32'({!h.wr, h.wr, h.wr, !h.wr && bus.mem_rdy, 2'b00, 1'b1}));
                chk("xfer_mem_addr", 32'(bus.mem_addr), 32'(h.addr));
                chk("xfer_word_idx", 32'(bus.word_idx), 32'(h.idx));
                chk("xfer_fill_sel", 32'(bus.fill_sel), 32'(h.sel));
            end
        end
    endtask

    // Advance the model by one clock using this cycle's inputs
    task automatic model_update();
        item_t             h;
        logic              gd;
        logic [ADDR_W-1:0] mb, vb;
        if (rst) begin
            model_reset();
        end else if (q.size() == 0) begin
            if (bus.i_miss || bus.d_miss) begin
`ifdef CACHE_MISS_CTRL_RR_EN
                gd = (bus.i_miss && bus.d_miss) ? m_ptr_d : bus.d_miss;
                m_ptr_d = !gd;
`else
                gd = bus.d_miss;
`endif
                mb = gd ? bus.d_miss_addr : bus.i_miss_addr;
                mb = mb - ADDR_W'(mb % WPL);
                vb = bus.d_victim_addr - ADDR_W'(bus.d_victim_addr % WPL);
                if (gd && bus.d_victim_dirty)
                    for (int k = 0; k < WPL; k++)
                        q.push_back('{done: 1'b0, wr: 1'b1, sel: 1'b1,
                                      addr: vb + ADDR_W'(k), idx: OFS_W'(k)});
                for (int k = 0; k < WPL; k++)
                    q.push_back('{done: 1'b0, wr: 1'b0, sel: gd,
                                  addr: mb + ADDR_W'(k), idx: OFS_W'(k)});
                q.push_back('{done: 1'b1, wr: 1'b0, sel: gd, addr: '0, idx: '0});
            end
        end else begin
            h = q[0];
            if (h.done) begin
                if (h.sel) drop_d = 1'b1;
                else       drop_i = 1'b1;
                void'(q.pop_front());
            end else begin
                m_sel = h.sel;
                m_idx = h.idx;
                if (bus.mem_rdy) void'(q.pop_front());
            end
        end
    endtask

    // One clock: inputs are already driven; requesters drop their miss the cycle after done
    task automatic cycle();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
        just_i = 1'b0;
        just_d = 1'b0;
        if (drop_i) begin bus.i_miss = 1'b0; drop_i = 1'b0; just_i = 1'b1; end
        if (drop_d) begin bus.d_miss = 1'b0; drop_d = 1'b0; just_d = 1'b1; end
    endtask

    // Run until the model has retired the transaction; rdy_mode 1 pulses mem_rdy every third cycle
    task automatic run_txn(input int max, input int rdy_mode, output int done_cyc, output logic first_d);
        done_cyc = -1;
        first_d  = 1'b0;
        for (int k = 0; k < max; k++) begin
            bus.mem_rdy = (rdy_mode == 1) ? (k % 3 == 2) : 1'b1;
            cycle();
            if ((obs_i_done || obs_d_done) && done_cyc < 0) begin
                done_cyc = k;
                first_d  = obs_d_done;
            end
            if (q.size() == 0 && k > 0) break;
        end
    endtask

    int   dc;
    logic fd;

    initial begin
        bus.i_miss = 0; bus.i_miss_addr = '0; bus.d_miss = 0; bus.d_miss_addr = '0;
        bus.d_victim_dirty = 0; bus.d_victim_addr = '0; bus.mem_rdy = 0;
        bus2.i_miss = 0; bus2.i_miss_addr = '0; bus2.d_miss = 0; bus2.d_miss_addr = '0;
        bus2.d_victim_dirty = 0; bus2.d_victim_addr = '0; bus2.mem_rdy = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_w8_busy", 32'(bus2.busy), 32'd0);
        cycle();

        // Clean I miss
        bus.i_miss = 1; bus.i_miss_addr = 16'h0123;
        run_txn(20, 0, dc, fd);
        chk("clean_i_done_cycle", 32'(dc), 32'd5);
        chk("clean_i_is_d", 32'(fd), 32'd0);

        // Dirty D miss
        bus.d_miss = 1; bus.d_miss_addr = 16'h0046;
        bus.d_victim_dirty = 1; bus.d_victim_addr = 16'h0A31;
        run_txn(20, 0, dc, fd);
        chk("dirty_d_done_cycle", 32'(dc), 32'd9);
        chk("dirty_d_is_d", 32'(fd), 32'd1);
        bus.d_victim_dirty = 0;

        // Two rounds of simultaneous misses: D, I, D, I
        for (int r = 0; r < 2; r++) begin
            bus.i_miss = 1; bus.i_miss_addr = 16'h0200;
            bus.d_miss = 1; bus.d_miss_addr = 16'h0201;
            run_txn(20, 0, dc, fd);
            chk("sim_first_done_cycle", 32'(dc), 32'd5);
            chk("sim_first_is_d", 32'(fd), 32'd1);
            run_txn(20, 0, dc, fd);
            chk("sim_second_done_cycle", 32'(dc), 32'd5);
            chk("sim_second_is_d", 32'(fd), 32'd0);
        end

        // Clean D miss with mem_rdy every third cycle
        bus.d_miss = 1; bus.d_miss_addr = 16'h1238;
        run_txn(40, 1, dc, fd);
        chk("slow_d_done_cycle", 32'(dc), 32'd12);

        // Reset during word 2 of FILL, then restart from word 0
        bus.i_miss = 1; bus.i_miss_addr = 16'h0555; bus.mem_rdy = 1;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        run_txn(20, 0, dc, fd);
        chk("rst_restart_done_cycle", 32'(dc), 32'd4);

        // Miss dropped mid-transaction still completes
        bus.d_miss = 1; bus.d_miss_addr = 16'h0777;
        cycle(); cycle();
        bus.d_miss = 0;
        run_txn(20, 0, dc, fd);
        chk("drop_d_done_cycle", 32'(dc), 32'd3);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bus.mem_rdy        = ($urandom_range(3) != 0);
            bus.d_victim_dirty = 1'($urandom_range(1));
            bus.d_victim_addr  = ADDR_W'($urandom);
            if (!bus.i_miss && !just_i && $urandom_range(2) == 0) begin
                bus.i_miss = 1; bus.i_miss_addr = ADDR_W'($urandom);
            end
            if (!bus.d_miss && !just_d && $urandom_range(2) == 0) begin
                bus.d_miss = 1;
                bus.d_miss_addr = ($urandom_range(3) == 0) ? bus.i_miss_addr : ADDR_W'($urandom);
            end
            cycle();
        end
        for (int n = 0; n < 100 && (q.size() != 0 || bus.i_miss || bus.d_miss); n++) begin
            bus.mem_rdy = 1;
            cycle();
        end
        chk("drain_i_miss", 32'(bus.i_miss), 32'd0);
        chk("drain_d_miss", 32'(bus.d_miss), 32'd0);

        // 8-word line, 12-bit address at the top of the address space
        bus2.d_miss = 1; bus2.d_miss_addr = 12'hFFF; bus2.mem_rdy = 1;
        for (int k = 0; k <= WPL2 + 1; k++) begin
            #1;
            if (k >= 1 && k <= WPL2) begin
                chk("w8_mem_re", 32'(bus2.mem_re), 32'd1);
                chk("w8_mem_addr", 32'(bus2.mem_addr), 32'(12'hFF8) + 32'(k - 1));
                chk("w8_word_idx", 32'(bus2.word_idx), 32'(k - 1));
            end
            if (k == WPL2 + 1) chk("w8_d_done", 32'(bus2.d_done), 32'd1);
            @(posedge clk);
            #1;
        end
        bus2.d_miss = 0;
        @(posedge clk);
        #1;
        bus2.d_miss = 1; bus2.d_miss_addr = 12'h013;
        @(posedge clk);
        #2;
        chk("w8_wrap_mem_re", 32'(bus2.mem_re), 32'd1);
        chk("w8_wrap_mem_addr", 32'(bus2.mem_addr), 32'h010);
        chk("w8_wrap_word_idx", 32'(bus2.word_idx), 32'd0);
        bus2.d_miss = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
